// File: rtl/core_pkg.sv
// Shared core definitions: default result width and destination encodings
// used by the execute-stage result distribution logic.
package core_pkg;

  localparam int RESULT_W = 32;

  localparam logic DEST_WB = 1'b0;
  localparam logic DEST_ST = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered valid/ready stage with same-cycle drain+load and a
// wrapping count of completed output transfers.
module demux_slot
  import core_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = out_valid && out_ready;

  // A load wins over a drain, so a slot that drains and refills stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/result_demux.sv
// Routes the execute-stage result stream to writeback (port 0) or the
// store-data path (port 1), each through its own registered slot.
module result_demux
  import core_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic ready0;
  logic ready1;
  logic load0;
  logic load1;

  // Each slot can accept when empty or draining this cycle; only the
  // selected slot gates the upstream.
  assign ready0   = !out0_valid || out0_ready;
  assign ready1   = !out1_valid || out1_ready;
  assign in_ready = (in_sel == DEST_ST) ? ready1 : ready0;

  assign load0 = in_valid && in_ready && (in_sel == DEST_WB);
  assign load1 = in_valid && in_ready && (in_sel == DEST_ST);

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .out_ready (out0_ready),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .cnt       (cnt0)
  );

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .out_ready (out1_ready),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_result_demux.sv
// Directed bench for result_demux: vector table for routing, backpressure and
// independence, plus hand sequences for throughput, counter wrap and reset.
module tb_result_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        eRdy;
    logic        eV0;
    logic [31:0] eD0;
    logic        eV1;
    logic [31:0] eD1;
    logic [7:0]  eC0;
    logic [7:0]  eC1;
  } vec_t;

  vec_t vecs[15];

  result_demux #(
    .WIDTH (32),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One vector spans a cycle: drive at negedge, check in_ready, then check state after posedge.
  task automatic applyStimulus(input int idx, input vec_t t);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    in_valid   = t.v;
    in_sel     = t.s;
    in_data    = t.d;
    out0_ready = t.r0;
    out1_ready = t.r1;
    #1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(t.eRdy));
    @(posedge clk);
    #1;
    checkOutput({tag, " out0_valid"}, 32'(out0_valid), 32'(t.eV0));
    checkOutput({tag, " out0_data"}, out0_data, t.eD0);
    checkOutput({tag, " out1_valid"}, 32'(out1_valid), 32'(t.eV1));
    checkOutput({tag, " out1_data"}, out1_data, t.eD1);
    checkOutput({tag, " cnt0"}, 32'(cnt0), 32'(t.eC0));
    checkOutput({tag, " cnt1"}, 32'(cnt1), 32'(t.eC1));
  endtask

  task automatic resetDut();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  initial begin
    //             v  s  data          r0 r1 rdy v0 d0            v1 d1            c0 c1
    vecs[0]  = '{1, 0, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0};
    vecs[1]  = '{0, 0, 32'h0,        1, 1, 1, 0, 32'hDEADBEEF, 0, 32'h0,        1, 0};
    vecs[2]  = '{1, 1, 32'h12345678, 1, 1, 1, 0, 32'hDEADBEEF, 1, 32'h12345678, 1, 0};
    vecs[3]  = '{0, 1, 32'h0,        1, 1, 1, 0, 32'hDEADBEEF, 0, 32'h12345678, 1, 1};
    vecs[4]  = '{1, 1, 32'hA5A5A5A5, 1, 0, 1, 0, 32'hDEADBEEF, 1, 32'hA5A5A5A5, 1, 1};
    vecs[5]  = '{1, 1, 32'h5A5A5A5A, 1, 0, 0, 0, 32'hDEADBEEF, 1, 32'hA5A5A5A5, 1, 1};
    vecs[6]  = '{1, 1, 32'h5A5A5A5A, 1, 0, 0, 0, 32'hDEADBEEF, 1, 32'hA5A5A5A5, 1, 1};
    vecs[7]  = '{1, 1, 32'h5A5A5A5A, 1, 1, 1, 0, 32'hDEADBEEF, 1, 32'h5A5A5A5A, 1, 2};
    vecs[8]  = '{0, 1, 32'h0,        1, 1, 1, 0, 32'hDEADBEEF, 0, 32'h5A5A5A5A, 1, 3};
    vecs[9]  = '{1, 0, 32'h11111111, 0, 1, 1, 1, 32'h11111111, 0, 32'h5A5A5A5A, 1, 3};
    vecs[10] = '{1, 1, 32'h22222222, 0, 0, 1, 1, 32'h11111111, 1, 32'h22222222, 1, 3};
    vecs[11] = '{1, 0, 32'h33333333, 0, 0, 0, 1, 32'h11111111, 1, 32'h22222222, 1, 3};
    vecs[12] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h11111111, 0, 32'h22222222, 2, 4};
    vecs[13] = '{1, 0, 32'h44444444, 0, 1, 1, 1, 32'h44444444, 0, 32'h22222222, 2, 4};
    vecs[14] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h44444444, 0, 32'h22222222, 3, 4};

    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2;
    checkOutput("reset out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("reset out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("reset out0_data", out0_data, 32'd0);
    checkOutput("reset out1_data", out1_data, 32'd0);
    checkOutput("reset cnt0", 32'(cnt0), 32'd0);
    checkOutput("reset cnt1", 32'(cnt1), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // Fill both slots, then pulse reset between edges with consumers ready.
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hCAFEF00D;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    in_sel = 1'b1; in_data = 32'h0BADF00D;
    @(negedge clk);
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1; in_sel = 1'b0;
    #1;
    checkOutput("full out0_valid", 32'(out0_valid), 32'd1);
    checkOutput("full out1_valid", 32'(out1_valid), 32'd1);
    checkOutput("full out1_data", out1_data, 32'h0BADF00D);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("midrst out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("midrst out0_data", out0_data, 32'd0);
    checkOutput("midrst out1_data", out1_data, 32'd0);
    checkOutput("midrst cnt0", 32'(cnt0), 32'd0);
    checkOutput("midrst cnt1", 32'(cnt1), 32'd0);
    checkOutput("midrst in_ready sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    checkOutput("midrst in_ready sel1", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("postrst cnt0", 32'(cnt0), 32'd0);
    checkOutput("postrst cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77777777;
    @(posedge clk);
    #1;
    checkOutput("resume out0_valid", 32'(out0_valid), 32'd1);
    checkOutput("resume out0_data", out0_data, 32'h77777777);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resume cnt0", 32'(cnt0), 32'd1);

    // Ten back-to-back words to port 0.
    resetDut();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h10000000 + 32'(i);
      #1;
      checkOutput($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d out0_valid", i), 32'(out0_valid), 32'd1);
      checkOutput($sformatf("stream%0d out0_data", i), out0_data, 32'h10000000 + 32'(i));
      checkOutput($sformatf("stream%0d cnt0", i), 32'(cnt0), 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stream out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("stream cnt0", 32'(cnt0), 32'd10);
    checkOutput("stream out1_valid", 32'(out1_valid), 32'd0);

    // 256 transfers wrap the 8-bit counter back to zero.
    resetDut();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("wrap cnt0 before", 32'(cnt0), 32'd255);
    checkOutput("wrap last data", out0_data, 32'd255);
    @(posedge clk);
    #1;
    checkOutput("wrap cnt0", 32'(cnt0), 32'd0);
    checkOutput("wrap cnt1", 32'(cnt1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
